// File: rtl/image_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : image_row_sequencer
// Description : Initiator side of the coprocessor image buffer. Walks rows
//               0..ROWS-1 of the selected source image. For each row it reads
//               the above/centre/below rows, captures them as a 3-row window,
//               hands the window to the filter datapath, accepts the filtered
//               row back, and writes it into the buffer's recent image.
//               Results are written one row late: the result for row r is
//               held in a pending register and written while processing row
//               r+1. This keeps in-place passes (img_idx=1) from overwriting a
//               row that a later window still has to read.
// Config      : ZERO_PAD_EN - when defined, the row above row 0 and the row
//               below row ROWS-1 are presented as all-zero instead of being
//               replicated from the clamped read address.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   start, src_sel             pass start pulse and source image select
//   busy, done                 pass in progress / end-of-pass pulse
//   raddr0..2, re, img_idx     buffer read port (above/centre/below rows)
//   rdata0..2                  buffer read data, one cycle after re
//   waddr, we, wdata           buffer write port (recent image)
//   win_valid/win_ready        window handshake to the filter datapath
//   win_top/mid/bot, win_row   window contents and centre row index
//   res_valid/res_ready        filtered-row handshake from the datapath
//   res_data                   filtered row
// ============================================================================
module image_row_sequencer #(
    parameter int ROWS  = 128,
    parameter int ROW_W = 3072
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             src_sel,
    output logic             busy,
    output logic             done,
    output logic [6:0]       raddr0,
    output logic [6:0]       raddr1,
    output logic [6:0]       raddr2,
    output logic             re,
    output logic             img_idx,
    input  logic [ROW_W-1:0] rdata0,
    input  logic [ROW_W-1:0] rdata1,
    input  logic [ROW_W-1:0] rdata2,
    output logic [8:0]       waddr,
    output logic             we,
    output logic [ROW_W-1:0] wdata,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [ROW_W-1:0] win_top,
    output logic [ROW_W-1:0] win_mid,
    output logic [ROW_W-1:0] win_bot,
    output logic [6:0]       win_row,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [ROW_W-1:0] res_data
);

    localparam logic [6:0] c_LAST_ROW = 7'(ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_PRESENT  = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_WRITE    = 3'd5,
        ST_FLUSH    = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [6:0]       r_row;       // centre row currently being processed
    logic             r_img;       // source image latched at start
    logic [ROW_W-1:0] r_top;
    logic [ROW_W-1:0] r_mid;
    logic [ROW_W-1:0] r_bot;
    logic [6:0]       r_win_row;
    logic [ROW_W-1:0] r_res;       // result of the current row
    logic [ROW_W-1:0] r_pend;      // result of the previous row, not yet written
    logic             r_pend_vld;

    logic             w_last_row;
    logic [ROW_W-1:0] w_top_in;
    logic [ROW_W-1:0] w_bot_in;

    assign w_last_row = (r_row == c_LAST_ROW);

`ifdef ZERO_PAD_EN
    // Edge rows are replaced by zeros; the clamped read data is discarded.
    assign w_top_in = (r_row == 7'd0) ? '0 : rdata0;
    assign w_bot_in = w_last_row      ? '0 : rdata2;
`else
    // Edge rows are replicated through the clamped read addresses.
    assign w_top_in = rdata0;
    assign w_bot_in = rdata2;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        re        = 1'b0;
        raddr0    = 7'd0;
        raddr1    = 7'd0;
        raddr2    = 7'd0;
        we        = 1'b0;
        waddr     = 9'd0;
        wdata     = '0;
        win_valid = 1'b0;
        res_ready = 1'b0;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                re     = 1'b1;
                raddr1 = r_row;
                raddr0 = (r_row == 7'd0) ? 7'd0 : r_row - 7'd1;
                raddr2 = w_last_row ? r_row : r_row + 7'd1;
                w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    w_next = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Row r-1 is written only now, after window r (the last one
                // that reads row r-1) has been captured.
                if (r_pend_vld) begin
                    we    = 1'b1;
                    waddr = {2'b00, r_row - 7'd1};
                    wdata = r_pend;
                end
                w_next = w_last_row ? ST_FLUSH : ST_FETCH;
            end
            ST_FLUSH: begin
                if (r_pend_vld) begin
                    we    = 1'b1;
                    waddr = {2'b00, c_LAST_ROW};
                    wdata = r_pend;
                end
                w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row      <= 7'd0;
            r_img      <= 1'b0;
            r_top      <= '0;
            r_mid      <= '0;
            r_bot      <= '0;
            r_win_row  <= 7'd0;
            r_res      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_row      <= 7'd0;
                        r_img      <= src_sel;
                        r_pend_vld <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    r_top     <= w_top_in;
                    r_mid     <= rdata1;
                    r_bot     <= w_bot_in;
                    r_win_row <= r_row;
                end
                ST_WAIT_RES: begin
                    if (res_valid) begin
                        r_res <= res_data;
                    end
                end
                ST_WRITE: begin
                    r_pend     <= r_res;
                    r_pend_vld <= 1'b1;
                    if (!w_last_row) begin
                        r_row <= r_row + 7'd1;
                    end
                end
                ST_FLUSH: begin
                    r_pend     <= '0;
                    r_pend_vld <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign img_idx = r_img;
    assign win_top = r_top;
    assign win_mid = r_mid;
    assign win_bot = r_bot;
    assign win_row = r_win_row;

endmodule
`default_nettype wire

// File: tb/tb_image_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_row_sequencer
// Description : Self-checking bench for image_row_sequencer. Models the image
//               buffer (original + recent images, 1-cycle read latency) and a
//               filter datapath, and checks every fetch, window and write
//               against a reference built from a snapshot of the source image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_row_sequencer;

    localparam int ROWS  = 128;
    localparam int ROW_W = 3072;
    localparam int MAX_CYC = 5000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             src_sel = 1'b0;
    logic             busy, done, re, img_idx, we;
    logic             win_valid, res_ready;
    logic             win_ready = 1'b0;
    logic             res_valid = 1'b0;
    logic [6:0]       raddr0, raddr1, raddr2, win_row;
    logic [8:0]       waddr;
    logic [ROW_W-1:0] rdata0 = '0, rdata1 = '0, rdata2 = '0;
    logic [ROW_W-1:0] wdata, win_top, win_mid, win_bot;
    logic [ROW_W-1:0] res_data;
    logic             mode = 1'b0;

    logic [ROW_W-1:0] mem_orig [ROWS];
    logic [ROW_W-1:0] mem_rec  [ROWS];
    logic [ROW_W-1:0] snap     [ROWS];

    typedef struct {
        int               addr;
        logic [ROW_W-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Filter datapath: inversion of the centre row, or top^bottom
    assign res_data = mode ? (win_top ^ win_bot) : ~win_mid;

    // Buffer read port, 1-cycle latency
    always @(posedge clk) begin
        if (re) begin
            rdata0 <= img_idx ? mem_rec[raddr0] : mem_orig[raddr0];
            rdata1 <= img_idx ? mem_rec[raddr1] : mem_orig[raddr1];
            rdata2 <= img_idx ? mem_rec[raddr2] : mem_orig[raddr2];
        end
    end

    image_row_sequencer #(.ROWS(ROWS), .ROW_W(ROW_W)) dut (
        .clk(clk), .rst(rst), .start(start), .src_sel(src_sel),
        .busy(busy), .done(done),
        .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2), .re(re),
        .img_idx(img_idx),
        .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2),
        .waddr(waddr), .we(we), .wdata(wdata),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_top(win_top), .win_mid(win_mid), .win_bot(win_bot),
        .win_row(win_row),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    task automatic fill_images();
        for (int r = 0; r < ROWS; r++) begin
            for (int w = 0; w < ROW_W / 32; w++) begin
                mem_orig[r][w*32 +: 32] = $urandom();
                mem_rec[r][w*32 +: 32]  = $urandom();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, re, we, win_valid, res_ready, img_idx} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {busy, done, re, we, win_valid, res_ready, img_idx});
        end
        n_cmp++;
        if ({raddr0, raddr1, raddr2, waddr, win_row} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_addr: got r0=%0d r1=%0d r2=%0d wa=%0d row=%0d required all 0",
                     raddr0, raddr1, raddr2, waddr, win_row);
        end
        n_cmp++;
        if ((win_top | win_mid | win_bot | wdata) !== '0) begin
            n_err++;
            $display("FAIL reset_data: got nonzero window/wdata required 0");
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One complete pass with full checking. stall_row: row whose window is
    // refused for 20 cycles (-1 none). restart_row: row at whose fetch a
    // second start pulse is issued (-1 none).
    task automatic run_pass(input logic src, input int stall_row, input int restart_row);
        int               fetch_k = 0;
        int               cycles = 0;
        int               n_wr = 0;
        int               n_done = 0;
        int               stall_cnt = 0;
        logic             prev_wv = 1'b0;
        logic [ROW_W-1:0] e_top, e_bot, h_top, h_mid, h_bot;
        logic [6:0]       h_row = 7'd0;
        logic [6:0]       e0, e2;
        wr_t              w;

        for (int k = 0; k < ROWS; k++) begin
            snap[k] = src ? mem_rec[k] : mem_orig[k];
        end
        exp_q.delete();
        for (int k = 0; k < ROWS; k++) begin
`ifdef ZERO_PAD_EN
            e_top = (k == 0) ? '0 : snap[k-1];
            e_bot = (k == ROWS-1) ? '0 : snap[k+1];
`else
            e_top = (k == 0) ? snap[0] : snap[k-1];
            e_bot = (k == ROWS-1) ? snap[ROWS-1] : snap[k+1];
`endif
            w.addr = k;
            w.data = src ? (e_top ^ e_bot) : ~snap[k];
            exp_q.push_back(w);
        end

        mode      = src;
        win_ready = 1'b1;
        res_valid = 1'b1;
        start     = 1'b1;
        src_sel   = src;
        @(negedge clk);
        src_sel   = ~src;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: got %b required 1", busy);
        end

        while (cycles < MAX_CYC) begin
            start = 1'b0;
            if (re) begin
                e0 = (fetch_k == 0) ? 7'd0 : 7'(fetch_k - 1);
                e2 = (fetch_k == ROWS-1) ? 7'(ROWS-1) : 7'(fetch_k + 1);
                n_cmp++;
                if (raddr0 !== e0 || raddr1 !== 7'(fetch_k) || raddr2 !== e2 || we !== 1'b0) begin
                    n_err++;
                    $display("FAIL fetch_addr row %0d: got (%0d,%0d,%0d) we=%b required (%0d,%0d,%0d) we=0",
                             fetch_k, raddr0, raddr1, raddr2, we, e0, fetch_k, e2);
                end
                if (fetch_k == restart_row) start = 1'b1;
                fetch_k++;
            end
            if (win_valid) begin
                if (!prev_wv) begin
`ifdef ZERO_PAD_EN
                    e_top = (fetch_k - 1 == 0) ? '0 : snap[fetch_k-2];
                    e_bot = (fetch_k - 1 == ROWS-1) ? '0 : snap[fetch_k];
`else
                    e_top = (fetch_k - 1 == 0) ? snap[0] : snap[fetch_k-2];
                    e_bot = (fetch_k - 1 == ROWS-1) ? snap[ROWS-1] : snap[fetch_k];
`endif
                    n_cmp++;
                    if (win_row !== 7'(fetch_k - 1) || img_idx !== src || win_top !== e_top ||
                        win_mid !== snap[fetch_k-1] || win_bot !== e_bot) begin
                        n_err++;
                        $display("FAIL window row %0d: got row=%0d img=%b top=%h mid=%h bot=%h required top=%h mid=%h bot=%h (low 32b)",
                                 fetch_k - 1, win_row, img_idx, win_top[31:0], win_mid[31:0], win_bot[31:0],
                                 e_top[31:0], snap[fetch_k-1][31:0], e_bot[31:0]);
                    end
                    h_top = win_top; h_mid = win_mid; h_bot = win_bot; h_row = win_row;
                end else begin
                    n_cmp++;
                    if (win_top !== h_top || win_mid !== h_mid || win_bot !== h_bot || win_row !== h_row) begin
                        n_err++;
                        $display("FAIL window_stable row %0d: got row=%0d required row=%0d with unchanged data",
                                 h_row, win_row, h_row);
                    end
                end
                win_ready = !(int'(win_row) == stall_row && stall_cnt < 20);
                if (!win_ready) begin
                    stall_cnt++;
                    n_cmp++;
                    if (re !== 1'b0 || we !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall_idle: got re=%b we=%b required 0 0", re, we);
                    end
                end
            end else begin
                win_ready = 1'b1;
            end
            prev_wv = win_valid;
            if (we) begin
                n_wr++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_write: got waddr=%0d required no write", waddr);
                end else begin
                    w = exp_q.pop_front();
                    if (waddr !== 9'(w.addr) || wdata !== w.data) begin
                        n_err++;
                        $display("FAIL write: got waddr=%0d wdata=%h required waddr=%0d wdata=%h (low 64b)",
                                 waddr, wdata[63:0], w.addr, w.data[63:0]);
                    end
                end
                mem_rec[waddr[6:0]] = wdata;
            end
            if (done) n_done++;
            if (!busy) break;
            @(negedge clk);
            cycles++;
        end

        start = 1'b0;
        n_cmp++;
        if (cycles >= MAX_CYC) begin
            n_err++;
            $display("FAIL pass_timeout: got %0d cycles required < %0d", cycles, MAX_CYC);
        end
        n_cmp++;
        if (n_wr != ROWS || exp_q.size() != 0 || fetch_k != ROWS) begin
            n_err++;
            $display("FAIL pass_counts: got writes=%0d left=%0d fetches=%0d required %0d 0 %0d",
                     n_wr, exp_q.size(), fetch_k, ROWS, ROWS);
        end
        n_cmp++;
        if (n_done != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL pass_done: got done_pulses=%0d busy=%b required 1 0", n_done, busy);
        end
        if (stall_row >= 0) begin
            n_cmp++;
            if (stall_cnt != 20) begin
                n_err++;
                $display("FAIL stall_len: got %0d required 20", stall_cnt);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_pass();
        int         cycles = 0;
        int         n_wr = 0;
        int         last_wa = -1;
        int         late = 0;
        mode      = 1'b0;
        res_valid = 1'b1;
        win_ready = 1'b1;
        start     = 1'b1;
        src_sel   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (cycles < MAX_CYC && !(win_valid && win_row == 7'd5)) begin
            if (we) begin
                n_wr++;
                last_wa = int'(waddr);
                mem_rec[waddr[6:0]] = wdata;
            end
            @(negedge clk);
            cycles++;
        end
        win_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || win_valid !== 1'b0 || we !== 1'b0 || re !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_pass: got busy=%b win_valid=%b we=%b re=%b required 0 0 0 0",
                     busy, win_valid, we, re);
        end
        n_cmp++;
        if (n_wr != 4 || last_wa != 3) begin
            n_err++;
            $display("FAIL reset_mid_writes: got %0d writes last=%0d required 4 last=3", n_wr, last_wa);
        end
        @(negedge clk);
        rst = 1'b0;
        win_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (we || busy) late++;
            @(negedge clk);
        end
        n_cmp++;
        if (late != 0) begin
            n_err++;
            $display("FAIL reset_no_write: got %0d active cycles required 0", late);
        end
    endtask

    task automatic test_full_pass();
        run_pass(1'b0, -1, -1);
    endtask

    task automatic test_in_place();
        run_pass(1'b1, -1, -1);
    endtask

    task automatic test_stall();
        run_pass(1'b0, 3, -1);
    endtask

    task automatic test_start_while_busy();
        run_pass(1'b1, -1, 10);
    endtask

    initial begin
        fill_images();
        test_reset();
        test_reset_mid_pass();
        test_full_pass();
        test_in_place();
        test_stall();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
